hancarlson_adder_pipe: RTL and testbench
========================================

Name: hancarlson_adder_pipe

Overview:
- Parametrised, pipelined Han-Carlson prefix adder/subtractor; successor to the fixed 32-bit combinational Han-Carlson adder.
- Width, pipeline-register spacing and tag width are configurable.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake on input and output with full backpressure.
- Sits between operand-issue logic and a result consumer in the adder-architecture library.

Parameters:
- WIDTH, 32, operand width; power of 2, range 4..128.
- REG_EVERY, 2, pipeline register after every REG_EVERY prefix levels; range 1..N.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (borrow-in when in_sub=1).
- in_sub  in  1  1 = subtract.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  sum/difference.
- out_cout  out  1  carry-out (subtract: 1 = no borrow).
- out_ovf  out  1  signed two's-complement overflow.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Operand preparation:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? ~in_cin : in_cin.
  - Result = a + b_eff + c0. With in_cin=0, subtract gives a-b; with in_cin=1 it gives a-b-1.
- Prefix tree:
  - N = log2(WIDTH)+1 levels.
  - Level 1 combines each odd/even bit pair.
  - Levels 2..N-1 form the Kogge-Stone-style odd-column tree at spans 2,4,...,WIDTH/2.
  - Level N is the grey fix-up that produces the even-column carries.
  - c0 is injected as generate at column -1, as in the existing adder.
- Outputs:
  - out_sum = p ^ carries.
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into MSB XOR carry out of MSB.
- Pipeline structure:
  - Stage 0: input register holding a, b_eff, c0 and tag.
  - Intermediate registers follow level k for every k with k % REG_EVERY == 0 and k < N.
  - A final output register follows level N, the sum XOR and the flag logic.
  - Latency L = 2 + floor((N-1)/REG_EVERY) cycles from accept to out_valid, with no stalls.
  - WIDTH=32, REG_EVERY=2 gives N=6, L=4.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - Each stage has a valid bit. A stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !v0 | stage0_advances, combinational from downstream valids and out_ready; bubbles collapse.
  - Throughput is 1 op/cycle when out_ready is held at 1.
  - Output data is stable while out_valid=1 and out_ready=0.
- Ordering and capacity:
  - Results emerge in acceptance order; no reordering or drops.
  - With out_ready=0, exactly L beats are accepted before in_ready falls to 0.
- Reset:
  - Asserting rst at any time clears all stage valids immediately; in-flight ops are discarded.
  - Output values during reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_tag=0, in_ready=0.
  - in_ready rises the first cycle after rst deasserts.
- Data registers need no reset except the output register; data in invalid stages is don't-care.
- Boundary cases:
  - Simultaneous accept and consume when full keeps occupancy at L.
  - Carry propagating across all WIDTH bits (all-ones + 1) must complete within the same latency.

Decomposition:
- Package hc_adder_pkg:
  - function hc_levels(WIDTH) = log2(WIDTH)+1.
  - function hc_latency(WIDTH, REG_EVERY).
  - function is_reg_level(k, REG_EVERY, N).
  - typedef gp_t = {g, p} vector struct.
- Reuse the existing black and grey cells.
- Sub-module hc_pipe_slice: a parametrised valid/data register stage with load-enable logic. It is instantiated per register point via generate; the prefix levels are generate loops in the top level.

Test Plan:
- WIDTH=32, REG_EVERY=2, out_ready=1; a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, tag=3 -> after 4 cycles: sum=0x00000000, cout=1, ovf=0, tag=3.
- a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, cout=0, ovf=1. Then sub: a=0x00000005, b=0x00000007, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Hold out_ready=0 and drive 6 back-to-back beats -> exactly 4 accepted, then in_ready=0. Release out_ready -> 4 results in order with correct tags, then the remaining 2 beats accepted.
- Assert rst mid-stream with 3 beats in flight -> out_valid drops in the same cycle and no stale result appears after release. The first post-reset beat returns after L cycles.
- Random out_ready toggling with 10k random operands for WIDTH in {4, 16, 64} and REG_EVERY in {1, 3} -> each result matches a reference model of a+b_eff+c0 (sum, cout, ovf, tag) with no loss or duplication.

Source files
------------

// File: rtl/hc_adder_pkg.sv
// Han-Carlson adder library: generate/propagate type, prefix cells
// and the level/latency helpers shared by the pipelined adder.
package hc_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int hc_levels(input int width);
        return $clog2(width) + 1;
    endfunction

    function automatic int hc_latency(input int width, input int reg_every);
        return 2 + (hc_levels(width) - 1) / reg_every;
    endfunction

    function automatic bit is_reg_level(input int k, input int reg_every,
                                        input int n);
        return (k > 0) && (k % reg_every == 0) && (k < n);
    endfunction

    function automatic gp_t black(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic logic grey(input gp_t hi, input logic lo_g);
        return hi.g | (hi.p & lo_g);
    endfunction

endpackage

// File: rtl/hancarlson_adder_pipe_slice.sv
// One valid/data pipeline register with backpressure-aware load enable.
module hc_pipe_slice #(
    parameter int DW       = 8,
    parameter bit RST_DATA = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    logic open;
    logic load;

    assign open = ~out_valid | out_ready;
    assign load = open & in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (open) begin
            out_valid <= in_valid;
        end
    end

    if (RST_DATA) begin : g_rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_data <= '0;
            end else if (load) begin
                out_data <= in_data;
            end
        end
    end else begin : g_nrst
        always_ff @(posedge clk) begin
            if (load) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/hancarlson_adder_pipe.sv
// Pipelined Han-Carlson adder/subtractor with valid/ready flow control.
// Prefix levels are generated here; register points use hc_pipe_slice.
module hancarlson_adder_pipe
    import hc_adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);
    localparam int N   = hc_levels(WIDTH);
    localparam int L   = hc_latency(WIDTH, REG_EVERY);
    localparam int DW0 = 2 * WIDTH + 1 + TAG_W;
    localparam int DWM = 3 * WIDTH + 1 + TAG_W;
    localparam int DWO = WIDTH + 2 + TAG_W;

    logic [L-1:0]   sv;
    logic [L-1:0]   dr;
    logic [DW0-1:0] d0;

    // Downstream readiness from valids only, so no ready ripple loop.
    for (genvar s = 0; s < L; s++) begin : g_dr
        if (s == L - 1) begin : g_last
            assign dr[s] = out_ready;
        end else begin : g_mid
            assign dr[s] = out_ready | ~&sv[L-1:s+1];
        end
    end

    assign in_ready  = ~rst & (~sv[0] | dr[0]);
    assign out_valid = sv[L-1];

    hc_pipe_slice #(.DW(DW0)) u_s0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  ({in_a, in_sub ? ~in_b : in_b, in_cin ^ in_sub, in_tag}),
        .out_valid(sv[0]),
        .out_ready(dr[0]),
        .out_data (d0)
    );

    for (genvar k = 0; k < N; k++) begin : lvl
        gp_t  [WIDTH-1:0] x;
        gp_t  [WIDTH-1:0] y;
        logic [WIDTH-1:0] xo;
        logic [WIDTH-1:0] yo;
        logic             xc;
        logic             yc;
        logic [TAG_W-1:0] xt;
        logic [TAG_W-1:0] yt;

        if (k == 0) begin : g_init
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            assign {a, b, xc, xt} = d0;
            assign xo = a ^ b;
            for (genvar i = 0; i < WIDTH; i++) begin : col
                if (i == 0) begin : g_cin
                    // Carry-in folded in as generate from column -1.
                    assign x[i] = '{g: (a[i] & b[i]) | (xo[i] & xc),
                                    p: xo[i]};
                end else begin : g_bit
                    assign x[i] = '{g: a[i] & b[i], p: xo[i]};
                end
            end
        end else begin : g_tree
            localparam int SPAN = 1 << (k - 1);
            assign xo = lvl[k-1].yo;
            assign xc = lvl[k-1].yc;
            assign xt = lvl[k-1].yt;
            for (genvar i = 0; i < WIDTH; i++) begin : col
                if (i % 2 == 1 && i >= SPAN) begin : g_blk
                    assign x[i] = black(lvl[k-1].y[i], lvl[k-1].y[i-SPAN]);
                end else begin : g_pass
                    assign x[i] = lvl[k-1].y[i];
                end
            end
        end

        if (is_reg_level(k, REG_EVERY, N)) begin : g_reg
            localparam int S = k / REG_EVERY;
            logic [DWM-1:0] q;
            hc_pipe_slice #(.DW(DWM)) u_slice (
                .clk      (clk),
                .rst      (rst),
                .in_valid (sv[S-1]),
                .in_data  ({x, xo, xc, xt}),
                .out_valid(sv[S]),
                .out_ready(dr[S]),
                .out_data (q)
            );
            assign {y, yo, yc, yt} = q;
        end else begin : g_wire
            assign y  = x;
            assign yo = xo;
            assign yc = xc;
            assign yt = xt;
        end
    end

    gp_t  [WIDTH-1:0] fin;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum;

    assign fin = lvl[N-1].y;

    // Grey fix-up: even columns pick up the completed odd column below.
    always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % 2 == 0 && i > 0) begin
                carry[i] = grey(fin[i], fin[i-1].g);
            end else begin
                carry[i] = fin[i].g;
            end
        end
    end

    assign sum = lvl[N-1].yo ^ {carry[WIDTH-2:0], lvl[N-1].yc};

    hc_pipe_slice #(.DW(DWO), .RST_DATA(1'b1)) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_valid (sv[L-2]),
        .in_data  ({sum, carry[WIDTH-1], carry[WIDTH-1] ^ carry[WIDTH-2],
                    lvl[N-1].yt}),
        .out_valid(sv[L-1]),
        .out_ready(dr[L-1]),
        .out_data ({out_sum, out_cout, out_ovf, out_tag})
    );

endmodule

// File: tb/tb_hancarlson_adder_pipe.sv
// Self-checking bench: directed flow-control steps on a 32-bit pipe plus
// randomized traffic across several widths against an arithmetic model.
module tb_hancarlson_adder_pipe;

    localparam int NC = 7;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    function automatic int cfg_w(input int c);
        case (c)
            0:       return 32;
            1, 2:    return 4;
            3, 4:    return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_r(input int c);
        return (c == 0) ? 2 : ((c % 2 == 1) ? 1 : 3);
    endfunction

    function automatic logic [63:0] msk(input int c);
        return (cfg_w(c) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                : (64'd1 << cfg_w(c)) - 64'd1;
    endfunction

    function automatic exp_t model(input int w, input logic [63:0] x,
                                   input logic [63:0] y, input logic ci,
                                   input logic sb, input logic [3:0] t);
        logic [64:0] m;
        logic [64:0] ye;
        logic [64:0] tot;
        exp_t r;
        m   = (65'd1 << w) - 65'd1;
        ye  = sb ? (~{1'b0, y} & m) : {1'b0, y};
        tot = {1'b0, x} + ye + 65'(ci ^ sb);
        r.sum  = 64'(tot & m);
        r.cout = tot[w];
        r.ovf  = (x[w-1] == ye[w-1]) && (r.sum[w-1] != x[w-1]);
        r.tag  = t;
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] a    [NC];
    logic [63:0] b    [NC];
    logic [63:0] sum  [NC];
    logic        cin  [NC];
    logic        sub  [NC];
    logic        iv   [NC];
    logic        ir   [NC];
    logic        ov   [NC];
    logic        ordy [NC];
    logic        cout [NC];
    logic        ovf  [NC];
    logic [3:0]  tg   [NC];
    logic [3:0]  otg  [NC];

    exp_t q [NC][$];

    int   checks = 0;
    int   errors = 0;
    logic acc0;
    logic got0;
    logic snap_ir;
    logic snap_ov;
    exp_t snap_out;
    exp_t last0;

    always #5 clk = ~clk;

    for (genvar gc = 0; gc < NC; gc++) begin : g_dut
        localparam int W = cfg_w(gc);
        logic [W-1:0] s;
        hancarlson_adder_pipe #(
            .WIDTH    (W),
            .REG_EVERY(cfg_r(gc)),
            .TAG_W    (4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[gc]),
            .in_ready (ir[gc]),
            .in_a     (a[gc][W-1:0]),
            .in_b     (b[gc][W-1:0]),
            .in_cin   (cin[gc]),
            .in_sub   (sub[gc]),
            .in_tag   (tg[gc]),
            .out_valid(ov[gc]),
            .out_ready(ordy[gc]),
            .out_sum  (s),
            .out_cout (cout[gc]),
            .out_ovf  (ovf[gc]),
            .out_tag  (otg[gc])
        );
        assign sum[gc] = 64'(s);
    end

    task automatic chk(input string nm, input logic [69:0] obs,
                       input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t o;
        @(negedge clk);
        acc0     = 1'b0;
        got0     = 1'b0;
        snap_ir  = ir[0];
        snap_ov  = ov[0];
        snap_out = '{sum: sum[0], cout: cout[0], ovf: ovf[0], tag: otg[0]};
        for (int c = 0; c < NC; c++) begin
            if (ov[c] && ordy[c]) begin
                o = '{sum: sum[c], cout: cout[c], ovf: ovf[c], tag: otg[c]};
                chk($sformatf("sb_nonempty%0d", c),
                    70'(q[c].size() > 0), 70'(1));
                if (q[c].size() > 0) begin
                    chk($sformatf("result%0d", c), o, q[c].pop_front());
                end
                if (c == 0) begin
                    got0  = 1'b1;
                    last0 = o;
                end
            end
            if (iv[c] && ir[c]) begin
                q[c].push_back(model(cfg_w(c), a[c], b[c], cin[c], sub[c],
                                     tg[c]));
                if (c == 0) acc0 = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string nm, input logic [31:0] x,
                       input logic [31:0] y, input logic ci, input logic sb,
                       input logic [3:0] t, input logic [31:0] es,
                       input logic ec, input logic eo);
        int n;
        exp_t e;
        a[0] = 64'(x); b[0] = 64'(y); cin[0] = ci; sub[0] = sb; tg[0] = t;
        iv[0] = 1'b1;
        cyc();
        chk({nm, "_acc"}, 70'(acc0), 70'(1));
        iv[0] = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!got0 && n < 20);
        chk({nm, "_lat"}, 70'(n), 70'(4));
        e = '{sum: 64'(es), cout: ec, ovf: eo, tag: t};
        chk({nm, "_res"}, last0, e);
    endtask

    initial begin
        int   k;
        int   n;
        int   nres;
        int   stale;
        logic held;
        exp_t hold;

        for (int c = 0; c < NC; c++) begin
            a[c] = '0; b[c] = '0; cin[c] = 1'b0; sub[c] = 1'b0;
            tg[c] = '0; iv[c] = 1'b0; ordy[c] = 1'b1;
        end

        @(posedge clk);
        #1;
        cyc();
        chk("rst_in_ready", 70'(snap_ir), 70'(0));
        chk("rst_out_valid", 70'(snap_ov), 70'(0));
        chk("rst_out_data", snap_out, 70'(0));
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", 70'(snap_ir), 70'(1));

        one("carry_all", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd3,
            32'h0, 1'b1, 1'b0);
        one("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'd5,
            32'h8000_0000, 1'b0, 1'b1);
        one("sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 4'd9,
            32'hFFFF_FFFE, 1'b0, 1'b0);
        one("sub_borrow", 32'h10, 32'h3, 1'b1, 1'b1, 4'd12,
            32'hC, 1'b1, 1'b0);

        // Backpressure: fill the pipe, then stream through while full.
        ordy[0] = 1'b0;
        k    = 0;
        held = 1'b0;
        hold = '0;
        for (int i = 0; i < 8; i++) begin
            a[0] = 64'(32'(k) * 32'h1111_1111);
            b[0] = 64'(32'hF0F0_0000 + 32'(k));
            cin[0] = 1'b0; sub[0] = k[0]; tg[0] = 4'(k);
            iv[0] = (k < 6);
            cyc();
            if (acc0) k++;
            if (snap_ov) begin
                if (!held) begin
                    hold = snap_out;
                    held = 1'b1;
                end else begin
                    chk("hold_stable", snap_out, hold);
                end
            end
        end
        chk("bp_accepted", 70'(k), 70'(4));
        chk("bp_ready_low", 70'(snap_ir), 70'(0));

        ordy[0] = 1'b1;
        a[0] = 64'(32'(k) * 32'h1111_1111);
        b[0] = 64'(32'hF0F0_0000 + 32'(k));
        sub[0] = k[0]; tg[0] = 4'(k); iv[0] = 1'b1;
        cyc();
        chk("full_acc_consume", 70'({acc0, got0}), 70'(3));
        chk("full_occupancy", 70'(q[0].size()), 70'(4));
        if (acc0) k++;
        nres = got0 ? 1 : 0;
        n = 0;
        while ((k < 6 || q[0].size() > 0) && n < 30) begin
            a[0] = 64'(32'(k) * 32'h1111_1111);
            b[0] = 64'(32'hF0F0_0000 + 32'(k));
            sub[0] = k[0]; tg[0] = 4'(k); iv[0] = (k < 6);
            cyc();
            if (acc0) k++;
            if (got0) nres++;
            n++;
        end
        iv[0] = 1'b0;
        chk("bp_results", 70'(nres), 70'(6));

        // Reset with three beats in flight.
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a[0] = 64'(32'hABCD_0000 + 32'(i)); b[0] = 64'(32'(i));
            sub[0] = 1'b0; tg[0] = 4'(i + 1); iv[0] = 1'b1;
            cyc();
        end
        iv[0] = 1'b0;
        cyc();
        chk("pre_rst_valid", 70'(ov[0]), 70'(1));
        rst = 1'b1;
        #1;
        chk("rst_drop_valid", 70'(ov[0]), 70'(0));
        chk("rst_drop_ready", 70'(ir[0]), 70'(0));
        q[0].delete();
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (got0) stale++;
        end
        chk("no_stale", 70'(stale), 70'(0));
        one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'd7,
            32'h2345_678A, 1'b0, 1'b0);

        // Randomized traffic on every configuration at once.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NC; c++) begin
                iv[c]   = ($urandom_range(0, 9) < 7);
                ordy[c] = ($urandom_range(0, 9) < 6);
                a[c]    = {$urandom, $urandom} & msk(c);
                b[c]    = {$urandom, $urandom} & msk(c);
                cin[c]  = 1'($urandom);
                sub[c]  = 1'($urandom);
                tg[c]   = 4'($urandom);
                if ($urandom_range(0, 15) == 0) begin
                    a[c] = msk(c); b[c] = 64'd1;
                    cin[c] = 1'b0; sub[c] = 1'b0;
                end
            end
            cyc();
        end
        for (int c = 0; c < NC; c++) begin
            iv[c]   = 1'b0;
            ordy[c] = 1'b1;
        end
        for (int i = 0; i < 20; i++) cyc();
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("drain%0d", c), 70'(q[c].size()), 70'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
